// File: rtl/axi_pkg.sv
// ----------------------------------------------------------------------------
// axi_pkg
// Shared AXI4-Lite definitions for the register-access fabric.
//   - MAX_ARB_MASTERS : largest number of upstream masters an arbiter supports
//   - RESP_*          : AXI response encodings (passed through, never generated)
//   - arb_wr_state_e  : write-path arbitration FSM states
//   - arb_rd_state_e  : read-path arbitration FSM states
// ----------------------------------------------------------------------------
package axi_pkg;

    localparam int MAX_ARB_MASTERS = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE      = 2'd0,
        WR_ADDR_DATA = 2'd1,
        WR_RESP      = 2'd2
    } arb_wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_RESP = 2'd2
    } arb_rd_state_e;

endpackage

// File: rtl/axi4_lite_rr_arbiter.sv
// ----------------------------------------------------------------------------
// axi4_lite_rr_arbiter
// Combinational round-robin pick: the first requester at or after ptr wins,
// wrapping at N.
//   req       in  N      : request vector
//   ptr       in  IDX_W  : highest-priority index (must be < N)
//   gnt_idx   out IDX_W  : winning index (0 when nothing requests)
//   gnt_valid out 1      : at least one request present
// ----------------------------------------------------------------------------
module axi4_lite_rr_arbiter #(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    // cand_idx[k] is the master examined k places after the pointer.
    logic [IDX_W-1:0] cand_idx [N];
    logic [N-1:0]     cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum           = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand_idx[gi]  = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                          : sum[IDX_W-1:0];
            assign cand_req[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest one overrides.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                gnt_idx   = cand_idx[i];
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// ----------------------------------------------------------------------------
// axi4_lite_arbiter
// Shares one AXI4-Lite slave port between NUM_M masters. Write (AW/W/B) and
// read (AR/R) paths are arbitrated independently by round-robin FSMs; a
// granted master owns its path until the response handshake. Pure routing,
// no buffering.
//   aclk, aresetn          : clock, asynchronous active-low reset
//   m_aw*/m_w*/m_b*        : per-master write channels, master i in slice i
//   m_ar*/m_r*             : per-master read channels, master i in slice i
//   s_aw*/s_w*/s_b*/s_ar*/s_r* : shared slave port
//   wr_gnt_idx, wr_busy    : write owner and write path ownership
//   rd_gnt_idx, rd_busy    : read owner and read path ownership
// ----------------------------------------------------------------------------
module axi4_lite_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_M      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_W      = $clog2(NUM_M)
) (
    input  logic                        aclk,
    input  logic                        aresetn,

    input  logic [NUM_M-1:0]            m_awvalid,
    output logic [NUM_M-1:0]            m_awready,
    input  logic [NUM_M*ADDR_WIDTH-1:0] m_awaddr,
    input  logic [NUM_M-1:0]            m_wvalid,
    output logic [NUM_M-1:0]            m_wready,
    input  logic [NUM_M*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_M*STRB_WIDTH-1:0] m_wstrb,
    output logic [NUM_M-1:0]            m_bvalid,
    input  logic [NUM_M-1:0]            m_bready,
    output logic [NUM_M*2-1:0]          m_bresp,

    input  logic [NUM_M-1:0]            m_arvalid,
    output logic [NUM_M-1:0]            m_arready,
    input  logic [NUM_M*ADDR_WIDTH-1:0] m_araddr,
    output logic [NUM_M-1:0]            m_rvalid,
    input  logic [NUM_M-1:0]            m_rready,
    output logic [NUM_M*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_M*2-1:0]          m_rresp,

    output logic                        s_awvalid,
    input  logic                        s_awready,
    output logic [ADDR_WIDTH-1:0]       s_awaddr,
    output logic                        s_wvalid,
    input  logic                        s_wready,
    output logic [DATA_WIDTH-1:0]       s_wdata,
    output logic [STRB_WIDTH-1:0]       s_wstrb,
    input  logic                        s_bvalid,
    output logic                        s_bready,
    input  logic [1:0]                  s_bresp,
    output logic                        s_arvalid,
    input  logic                        s_arready,
    output logic [ADDR_WIDTH-1:0]       s_araddr,
    input  logic                        s_rvalid,
    output logic                        s_rready,
    input  logic [DATA_WIDTH-1:0]       s_rdata,
    input  logic [1:0]                  s_rresp,

    output logic [IDX_W-1:0]            wr_gnt_idx,
    output logic                        wr_busy,
    output logic [IDX_W-1:0]            rd_gnt_idx,
    output logic                        rd_busy
);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_M - 1)) ? '0 : idx + 1'b1;
    endfunction

    // ---------------- per-master unpacked views ----------------
    logic [ADDR_WIDTH-1:0] awaddr_arr [NUM_M];
    logic [DATA_WIDTH-1:0] wdata_arr  [NUM_M];
    logic [STRB_WIDTH-1:0] wstrb_arr  [NUM_M];
    logic [ADDR_WIDTH-1:0] araddr_arr [NUM_M];

    // ---------------- write path state ----------------
    arb_wr_state_e    wr_state_reg, wr_state_next;
    logic [IDX_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [IDX_W-1:0] wr_gnt_idx_reg, wr_gnt_idx_next;
    logic             aw_done_reg, aw_done_next;
    logic             w_done_reg, w_done_next;
    logic [IDX_W-1:0] wr_pick;
    logic             wr_pick_valid;

    // ---------------- read path state ----------------
    arb_rd_state_e    rd_state_reg, rd_state_next;
    logic [IDX_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [IDX_W-1:0] rd_gnt_idx_reg, rd_gnt_idx_next;
    logic [IDX_W-1:0] rd_pick;
    logic             rd_pick_valid;

    logic wr_addr_phase, wr_resp_phase, rd_addr_phase, rd_resp_phase;
    logic aw_fire, w_fire, b_fire, ar_fire, r_fire;

    axi4_lite_rr_arbiter #(.N(NUM_M)) u_wr_rr (
        .req       (m_awvalid | m_wvalid),
        .ptr       (wr_ptr_reg),
        .gnt_idx   (wr_pick),
        .gnt_valid (wr_pick_valid)
    );

    axi4_lite_rr_arbiter #(.N(NUM_M)) u_rd_rr (
        .req       (m_arvalid),
        .ptr       (rd_ptr_reg),
        .gnt_idx   (rd_pick),
        .gnt_valid (rd_pick_valid)
    );

    assign wr_addr_phase = (wr_state_reg == WR_ADDR_DATA);
    assign wr_resp_phase = (wr_state_reg == WR_RESP);
    assign rd_addr_phase = (rd_state_reg == RD_ADDR);
    assign rd_resp_phase = (rd_state_reg == RD_RESP);

    assign aw_fire = s_awvalid & s_awready;
    assign w_fire  = s_wvalid & s_wready;
    assign b_fire  = s_bvalid & s_bready;
    assign ar_fire = s_arvalid & s_arready;
    assign r_fire  = s_rvalid & s_rready;

    // ---------------- write FSM ----------------
    always_comb begin
        wr_state_next   = wr_state_reg;
        wr_ptr_next     = wr_ptr_reg;
        wr_gnt_idx_next = wr_gnt_idx_reg;
        aw_done_next    = aw_done_reg;
        w_done_next     = w_done_reg;
        case (wr_state_reg)
            WR_IDLE: begin
                if (wr_pick_valid) begin
                    wr_gnt_idx_next = wr_pick;
                    aw_done_next    = 1'b0;
                    w_done_next     = 1'b0;
                    wr_state_next   = WR_ADDR_DATA;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W are independent; either order or both at once.
                aw_done_next = aw_done_reg | aw_fire;
                w_done_next  = w_done_reg | w_fire;
                if (aw_done_next && w_done_next) begin
                    wr_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_fire) begin
                    wr_ptr_next   = next_idx(wr_gnt_idx_reg);
                    wr_state_next = WR_IDLE;
                end
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    // ---------------- read FSM ----------------
    always_comb begin
        rd_state_next   = rd_state_reg;
        rd_ptr_next     = rd_ptr_reg;
        rd_gnt_idx_next = rd_gnt_idx_reg;
        case (rd_state_reg)
            RD_IDLE: begin
                if (rd_pick_valid) begin
                    rd_gnt_idx_next = rd_pick;
                    rd_state_next   = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (ar_fire) begin
                    rd_state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_fire) begin
                    rd_ptr_next   = next_idx(rd_gnt_idx_reg);
                    rd_state_next = RD_IDLE;
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_reg   <= WR_IDLE;
            wr_ptr_reg     <= '0;
            wr_gnt_idx_reg <= '0;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
            rd_state_reg   <= RD_IDLE;
            rd_ptr_reg     <= '0;
            rd_gnt_idx_reg <= '0;
        end else begin
            wr_state_reg   <= wr_state_next;
            wr_ptr_reg     <= wr_ptr_next;
            wr_gnt_idx_reg <= wr_gnt_idx_next;
            aw_done_reg    <= aw_done_next;
            w_done_reg     <= w_done_next;
            rd_state_reg   <= rd_state_next;
            rd_ptr_reg     <= rd_ptr_next;
            rd_gnt_idx_reg <= rd_gnt_idx_next;
        end
    end

    // ---------------- slave-side mux ----------------
    // A finished channel has its valid forced low so the slave sees exactly
    // one AW and one W per transaction even if the master is slow to drop.
    assign s_awvalid = wr_addr_phase & ~aw_done_reg & m_awvalid[wr_gnt_idx_reg];
    assign s_awaddr  = awaddr_arr[wr_gnt_idx_reg];
    assign s_wvalid  = wr_addr_phase & ~w_done_reg & m_wvalid[wr_gnt_idx_reg];
    assign s_wdata   = wdata_arr[wr_gnt_idx_reg];
    assign s_wstrb   = wstrb_arr[wr_gnt_idx_reg];
    assign s_bready  = wr_resp_phase & m_bready[wr_gnt_idx_reg];

    assign s_arvalid = rd_addr_phase & m_arvalid[rd_gnt_idx_reg];
    assign s_araddr  = araddr_arr[rd_gnt_idx_reg];
    assign s_rready  = rd_resp_phase & m_rready[rd_gnt_idx_reg];

    // ---------------- master-side demux ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_master
            localparam logic [IDX_W-1:0] GI = IDX_W'(gi);
            logic wr_sel, rd_sel;

            assign awaddr_arr[gi] = m_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi]  = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign wstrb_arr[gi]  = m_wstrb[gi*STRB_WIDTH +: STRB_WIDTH];
            assign araddr_arr[gi] = m_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

            assign wr_sel = (wr_gnt_idx_reg == GI);
            assign rd_sel = (rd_gnt_idx_reg == GI);

            assign m_awready[gi] = wr_addr_phase & ~aw_done_reg & wr_sel & s_awready;
            assign m_wready[gi]  = wr_addr_phase & ~w_done_reg & wr_sel & s_wready;
            assign m_bvalid[gi]  = wr_resp_phase & wr_sel & s_bvalid;
            assign m_bresp[gi*2 +: 2] = (wr_resp_phase & wr_sel) ? s_bresp : 2'b00;

            assign m_arready[gi] = rd_addr_phase & rd_sel & s_arready;
            assign m_rvalid[gi]  = rd_resp_phase & rd_sel & s_rvalid;
            assign m_rresp[gi*2 +: 2] = (rd_resp_phase & rd_sel) ? s_rresp : 2'b00;
            assign m_rdata[gi*DATA_WIDTH +: DATA_WIDTH] =
                (rd_resp_phase & rd_sel) ? s_rdata : '0;
        end
    endgenerate

    assign wr_gnt_idx = wr_gnt_idx_reg;
    assign rd_gnt_idx = rd_gnt_idx_reg;
    assign wr_busy    = (wr_state_reg != WR_IDLE);
    assign rd_busy    = (rd_state_reg != RD_IDLE);

endmodule
